// File: rtl/button_pkg.sv
// Shared types and defaults for the button press arbiter.
package button_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StOffer,
      StLockout
   } state_e;

   localparam int unsigned DefaultNumButtons    = 4;
   // 50 ms at a 20 ns clock
   localparam int unsigned DefaultLockoutCounts = 2500000;

endpackage

// File: rtl/button_arbiter_if.sv
// Press handshake towards the game FSM: the arbiter is master, the consumer is slave.
interface button_arbiter_if
   import button_pkg::*;
#(
   parameter int unsigned NUM_BUTTONS = DefaultNumButtons
);
   localparam int unsigned IdxW = $clog2(NUM_BUTTONS);

   logic            press_valid;
   logic [IdxW-1:0] press_index;
   logic            press_ready;

   modport master (
      output press_valid,
      output press_index,
      input  press_ready
   );

   modport slave (
      input  press_valid,
      input  press_index,
      output press_ready
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request searching upward from last_grant+1.
module rr_arbiter #(
   parameter int unsigned NUM_BUTTONS = 4,
   localparam int unsigned IdxW = $clog2(NUM_BUTTONS)
) (
   input  logic [NUM_BUTTONS-1:0] req_i,
   input  logic [IdxW-1:0]        last_grant_i,
   output logic [IdxW-1:0]        grant_o,
   output logic                   any_req_o
);

   int unsigned            start_idx;
   logic [NUM_BUTTONS-1:0] req_rot;
   logic                   found;

   always_comb begin
      start_idx = (32'(last_grant_i) + 32'd1) % NUM_BUTTONS;
      // Rotate so bit 0 is the highest-priority requester.
      req_rot   = NUM_BUTTONS'({req_i, req_i} >> start_idx);
      grant_o   = '0;
      found     = 1'b0;
      any_req_o = |req_i;
      for (int unsigned k = 0; k < NUM_BUTTONS; k++) begin
         if (!found && req_rot[k]) begin
            found   = 1'b1;
            grant_o = IdxW'((start_idx + k) % NUM_BUTTONS);
         end
      end
   end

endmodule

// File: rtl/button_arbiter.sv
// Serialises button rising edges into a valid/ready press stream with a post-press lockout.
module button_arbiter
   import button_pkg::*;
#(
   parameter int unsigned NUM_BUTTONS    = DefaultNumButtons,
   parameter int unsigned LOCKOUT_COUNTS = DefaultLockoutCounts
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable_i,
   input  logic [NUM_BUTTONS-1:0] buttons_i,
   button_arbiter_if.master       press_if,
   output logic [NUM_BUTTONS-1:0] pending_o
);

   localparam int unsigned     IdxW    = $clog2(NUM_BUTTONS);
   localparam int unsigned     CntW    = (LOCKOUT_COUNTS > 0) ? $clog2(LOCKOUT_COUNTS + 1) : 1;
   localparam logic [CntW-1:0] CntLast = (LOCKOUT_COUNTS > 0) ? CntW'(LOCKOUT_COUNTS - 1) : '0;
   localparam logic [CntW-1:0] CntMax  = '1;

   logic [NUM_BUTTONS-1:0] prev_q;
   logic [NUM_BUTTONS-1:0] pending_q, pending_d;
   logic [NUM_BUTTONS-1:0] rise, hs_mask;
   logic                   handshake;
   state_e                 state_q;
   logic                   valid_q;
   logic [IdxW-1:0]        index_q;
   logic [IdxW-1:0]        last_grant_q;
   logic [CntW-1:0]        cnt_q;
   logic [IdxW-1:0]        grant;
   logic                   any_req;

   always_comb begin
      rise      = buttons_i & ~prev_q;
      handshake = enable_i & valid_q & press_if.press_ready;
      hs_mask   = handshake ? (NUM_BUTTONS'(1) << index_q) : '0;
      // A rise in the handshake cycle wins over the clear, so the re-press survives.
      pending_d = enable_i ? ((pending_q & ~hs_mask) | rise) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q    <= '0;
         pending_q <= '0;
      end else begin
         prev_q    <= buttons_i;
         pending_q <= pending_d;
      end
   end

   rr_arbiter #(
      .NUM_BUTTONS (NUM_BUTTONS)
   ) u_rr (
      .req_i        (pending_q),
      .last_grant_i (last_grant_q),
      .grant_o      (grant),
      .any_req_o    (any_req)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         valid_q      <= 1'b0;
         index_q      <= '0;
         last_grant_q <= IdxW'(NUM_BUTTONS - 1);
         cnt_q        <= '0;
      end else if (!enable_i) begin
         // Flush any offer in flight; the press is dropped without a handshake.
         state_q <= StIdle;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (any_req) begin
                  index_q <= grant;
                  valid_q <= 1'b1;
                  state_q <= StOffer;
               end
            end
            StOffer: begin
               if (press_if.press_ready) begin
                  valid_q      <= 1'b0;
                  last_grant_q <= index_q;
                  cnt_q        <= '0;
                  state_q      <= (LOCKOUT_COUNTS == 0) ? StIdle : StLockout;
               end
            end
            StLockout: begin
               if (cnt_q == CntLast) begin
                  state_q <= StIdle;
               end else if (cnt_q != CntMax) begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign press_if.press_valid = valid_q;
   assign press_if.press_index = index_q;
   assign pending_o            = pending_q;

endmodule

// File: tb/tb_button_arbiter.sv
// Directed scenarios plus randomized traffic against a time-based press model.
module tb_button_arbiter;

   localparam int N = 4;
   localparam int L = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en  = 1'b1;
   logic         rdy = 1'b1;
   logic [N-1:0] btn = '0;
   logic [N-1:0] pend;

   int vectors = 0;
   int errors  = 0;

   button_arbiter_if #(.NUM_BUTTONS(N)) pif ();
   assign pif.press_ready = rdy;

   button_arbiter #(
      .NUM_BUTTONS    (N),
      .LOCKOUT_COUNTS (L)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable_i  (en),
      .buttons_i (btn),
      .press_if  (pif),
      .pending_o (pend)
   );

   always #5 clk = ~clk;

   // Reference model: pending set, current offer, and the earliest edge a new pick may happen.
   logic [N-1:0] m_pend, m_prev;
   bit           m_offer;
   int           m_idx, m_last;
   longint       cyc = 0;
   longint       m_free_at = 0;

   task automatic model_step();
      logic [N-1:0] rise, old;
      rise   = btn & ~m_prev;
      m_prev = btn;
      if (rst) begin
         m_pend = '0; m_prev = '0; m_offer = 0; m_idx = 0; m_last = N - 1;
         m_free_at = cyc + 1;
      end else if (!en) begin
         m_pend = '0; m_offer = 0; m_free_at = cyc + 1;
      end else begin
         old = m_pend;
         if (m_offer && rdy) begin
            m_pend[m_idx] = 1'b0;
            m_last        = m_idx;
            m_offer       = 0;
            m_free_at     = cyc + L + 1;
         end else if (!m_offer && cyc >= m_free_at && old != 0) begin
            for (int k = 1; k <= N; k++) begin
               if (!m_offer && old[(m_last + k) % N]) begin
                  m_idx   = (m_last + k) % N;
                  m_offer = 1;
               end
            end
         end
         m_pend = m_pend | rise;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; btn = '0; en = 1'b1; rdy = 1'b1;
      idle(2);
      rst = 1'b0;
      vectors++;
      if (pif.press_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b want 0", pif.press_valid);
      end
      vectors++;
      if (pif.press_index !== 2'd0) begin
         errors++; $display("FAIL reset_index: got %0d want 0", pif.press_index);
      end
      vectors++;
      if (pend !== 4'b0000) begin
         errors++; $display("FAIL reset_pending: got %b want 0000", pend);
      end
   endtask

   task automatic test_single();
      longint e_h;
      btn = 4'b0100;
      tick();
      vectors++;
      if (pend !== 4'b0100 || pif.press_valid !== 1'b0) begin
         errors++; $display("FAIL single_edge_t: pending %b valid %b want 0100 0", pend, pif.press_valid);
      end
      tick();
      vectors++;
      if (pif.press_valid !== 1'b1 || pif.press_index !== 2'd2) begin
         errors++; $display("FAIL single_offer: valid %b index %0d want 1 2", pif.press_valid, pif.press_index);
      end
      tick();
      e_h = cyc;
      vectors++;
      if (pif.press_valid !== 1'b0 || pend !== 4'b0000) begin
         errors++; $display("FAIL single_drop: valid %b pending %b want 0 0000", pif.press_valid, pend);
      end
      btn = '0; tick(); btn = 4'b0100; tick(); btn = '0;
      for (int i = 0; i < 20 && !pif.press_valid; i++) tick();
      vectors++;
      if (pif.press_valid !== 1'b1 || cyc - e_h != 5) begin
         errors++; $display("FAIL single_spacing: valid %b offer %0d edges after handshake want 5", pif.press_valid, cyc - e_h);
      end
      tick();
   endtask

   task automatic test_rr();
      int q[$];
      int g0, g1;
      idle(8);
      btn = 4'b1001; tick(); btn = '0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (pif.press_valid) q.push_back(int'(pif.press_index));
      end
      g0 = (q.size() > 0) ? q[0] : -1;
      g1 = (q.size() > 1) ? q[1] : -1;
      vectors++;
      if (q.size() != 2 || g0 != 3 || g1 != 0) begin
         errors++; $display("FAIL rr_order: got %0d offers first %0d then %0d want 2 offers 3 then 0", q.size(), g0, g1);
      end
   endtask

   task automatic test_simultaneous();
      int           idxs[$];
      logic [N-1:0] pends[$];
      longint       cycs[$];
      logic [N-1:0] exp_p;
      idle(2);
      btn = 4'b1111; tick(); btn = '0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (pif.press_valid) begin
            idxs.push_back(int'(pif.press_index)); pends.push_back(pend); cycs.push_back(cyc);
         end
      end
      vectors++;
      if (idxs.size() != 4) begin
         errors++; $display("FAIL simul_count: got %0d offers want 4", idxs.size());
      end
      for (int k = 0; k < idxs.size() && k < 4; k++) begin
         exp_p = 4'b1111 << k;
         vectors++;
         if (idxs[k] != k || pends[k] !== exp_p) begin
            errors++; $display("FAIL simul_step%0d: index %0d pending %b want %0d %b", k, idxs[k], pends[k], k, exp_p);
         end
         if (k > 0) begin
            vectors++;
            if (cycs[k] - cycs[k-1] != L + 2) begin
               errors++; $display("FAIL simul_gap%0d: got %0d want %0d", k, cycs[k] - cycs[k-1], L + 2);
            end
         end
      end
      vectors++;
      if (pend !== 4'b0000) begin
         errors++; $display("FAIL simul_final_pending: got %b want 0000", pend);
      end
   endtask

   task automatic test_backpressure();
      int nvalid = 0;
      idle(8);
      rdy = 1'b0; btn = 4'b0010; tick(); btn = '0;
      for (int i = 0; i < 10 && !pif.press_valid; i++) tick();
      repeat (10) begin
         tick();
         vectors++;
         if (pif.press_valid !== 1'b1 || pif.press_index !== 2'd1) begin
            errors++; $display("FAIL bp_hold: valid %b index %0d want 1 1", pif.press_valid, pif.press_index);
         end
      end
      rdy = 1'b1; tick();
      vectors++;
      if (pif.press_valid !== 1'b0) begin
         errors++; $display("FAIL bp_accept: valid %b want 0", pif.press_valid);
      end
      repeat (15) begin
         tick();
         if (pif.press_valid) nvalid++;
      end
      vectors++;
      if (nvalid != 0) begin
         errors++; $display("FAIL bp_single_transfer: got %0d extra offer cycles want 0", nvalid);
      end
   endtask

   task automatic test_lockout_flush();
      int nvalid = 0;
      idle(8);
      btn = 4'b0001; tick(); btn = '0;
      for (int i = 0; i < 10 && !pif.press_valid; i++) tick();
      tick();
      btn = 4'b0010; tick(); btn = '0;
      vectors++;
      if (pend !== 4'b0010 || pif.press_valid !== 1'b0) begin
         errors++; $display("FAIL lock_capture: pending %b valid %b want 0010 0", pend, pif.press_valid);
      end
      for (int i = 0; i < 20 && !pif.press_valid; i++) tick();
      vectors++;
      if (pif.press_valid !== 1'b1 || pif.press_index !== 2'd1) begin
         errors++; $display("FAIL lock_offer: valid %b index %0d want 1 1", pif.press_valid, pif.press_index);
      end
      tick();
      idle(8);
      rdy = 1'b0; btn = 4'b0100; tick(); btn = '0;
      for (int i = 0; i < 10 && !pif.press_valid; i++) tick();
      en = 1'b0; tick();
      vectors++;
      if (pif.press_valid !== 1'b0 || pend !== 4'b0000) begin
         errors++; $display("FAIL flush: valid %b pending %b want 0 0000", pif.press_valid, pend);
      end
      btn = 4'b1000; tick(); btn = '0; tick();
      en = 1'b1; rdy = 1'b1;
      repeat (20) begin
         tick();
         if (pif.press_valid) nvalid++;
      end
      vectors++;
      if (nvalid != 0 || pend !== 4'b0000) begin
         errors++; $display("FAIL disabled_press: offers %0d pending %b want 0 0000", nvalid, pend);
      end
   endtask

   task automatic test_same_cycle();
      longint e_h;
      idle(8);
      rdy = 1'b0; btn = 4'b0010; tick(); btn = '0;
      for (int i = 0; i < 10 && !pif.press_valid; i++) tick();
      rdy = 1'b1; btn = 4'b0010; tick(); btn = '0;
      e_h = cyc;
      vectors++;
      if (pif.press_valid !== 1'b0 || pend !== 4'b0010) begin
         errors++; $display("FAIL repress_keep: valid %b pending %b want 0 0010", pif.press_valid, pend);
      end
      for (int i = 0; i < 20 && !pif.press_valid; i++) tick();
      vectors++;
      if (pif.press_valid !== 1'b1 || pif.press_index !== 2'd1 || cyc - e_h != L + 1) begin
         errors++; $display("FAIL repress_offer: valid %b index %0d after %0d edges want 1 1 %0d",
                            pif.press_valid, pif.press_index, cyc - e_h, L + 1);
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         btn = btn ^ N'($urandom & $urandom);
         en  = ($urandom_range(0, 19) != 0);
         rdy = ($urandom_range(0, 2) != 0);
         rst = ($urandom_range(0, 199) == 0);
         tick();
         vectors++;
         if (pif.press_valid !== m_offer || pend !== m_pend ||
             (m_offer && int'(pif.press_index) != m_idx)) begin
            errors++;
            $display("FAIL random@%0d: valid %b index %0d pending %b want %b %0d %b",
                     cyc, pif.press_valid, pif.press_index, pend, m_offer, m_idx, m_pend);
         end
      end
      rst = 1'b0; en = 1'b1; rdy = 1'b1; btn = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_rr();
      rst = 1'b1; tick(); rst = 1'b0;
      test_simultaneous();
      test_backpressure();
      test_lockout_flush();
      test_same_cycle();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
